// File: rtl/seq_mul_div.sv
// Iterative multiply/divide engine: shift-add multiply (N x N -> 2N) and restoring
// divide (2N / N -> 2N quotient, N remainder), one array row per clock.
module seq_mul_div #(
   parameter int unsigned N = 4,
   localparam int unsigned CW = $clog2(2*N) + 1
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           start,
   input  logic           mode,
   input  logic [N-1:0]   b_in,
   input  logic [2*N-1:0] l_in,
   output logic           busy,
   output logic           done,
   output logic [2*N-1:0] mul_out,
   output logic [2*N-1:0] quot_out,
   output logic [N-1:0]   rem_out,
   output logic           div_zero
);

   localparam int unsigned W2 = 2 * N;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   state_e          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            mode_q, mode_d;
   logic [N-1:0]    b_q, b_d;
   logic [W2-1:0]   l_q, l_d;
   logic [W2-1:0]   mcand_q, mcand_d;
   logic [W2-1:0]   acc_q, acc_d;
   logic [N-1:0]    prem_q, prem_d;
   logic            busy_q, busy_d;
   logic            done_q, done_d;
   logic [W2-1:0]   mul_out_q, mul_out_d;
   logic [W2-1:0]   quot_out_q, quot_out_d;
   logic [N-1:0]    rem_out_q, rem_out_d;
   logic            div_zero_q, div_zero_d;

   logic [N:0]      shifted;
   logic            trial_ok;
   logic [N-1:0]    prem_step;
   logic [W2-1:0]   acc_step;

   // One array row: restoring trial subtract (divide) or conditional add (multiply).
   // A set top bit of the shifted remainder already exceeds any N-bit divisor.
   always_comb begin
      shifted   = {prem_q, l_q[W2-1]};
      trial_ok  = shifted[N] | (shifted[N-1:0] >= b_q);
      prem_step = trial_ok ? (shifted[N-1:0] - b_q) : shifted[N-1:0];
      if (mode_q) begin
         acc_step = {acc_q[W2-2:0], trial_ok};
      end else begin
         acc_step = l_q[0] ? (acc_q + mcand_q) : acc_q;
      end
   end

   // Next-state and datapath control.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      mode_d     = mode_q;
      b_d        = b_q;
      l_d        = l_q;
      mcand_d    = mcand_q;
      acc_d      = acc_q;
      prem_d     = prem_q;
      mul_out_d  = mul_out_q;
      quot_out_d = quot_out_q;
      rem_out_d  = rem_out_q;
      div_zero_d = div_zero_q;

      case (state_q)
         IDLE, DONE: begin
            if (start) begin
               mode_d     = mode;
               b_d        = b_in;
               l_d        = l_in;
               mcand_d    = W2'(b_in);
               acc_d      = '0;
               prem_d     = '0;
               cnt_d      = mode ? CW'(2 * N) : CW'(N);
               div_zero_d = 1'b0;
               if (mode && (b_in == '0)) begin
                  state_d    = DONE;
                  quot_out_d = '1;
                  rem_out_d  = l_in[N-1:0];
                  div_zero_d = 1'b1;
               end else begin
                  state_d = RUN;
               end
            end else begin
               state_d = IDLE;
            end
         end

         RUN: begin
            cnt_d = cnt_q - CW'(1);
            acc_d = acc_step;
            if (mode_q) begin
               prem_d = prem_step;
               l_d    = {l_q[W2-2:0], 1'b0};
            end else begin
               l_d     = {1'b0, l_q[W2-1:1]};
               mcand_d = {mcand_q[W2-2:0], 1'b0};
            end
            if (cnt_q == CW'(1)) begin
               state_d = DONE;
               if (mode_q) begin
                  quot_out_d = acc_step;
                  rem_out_d  = prem_step;
               end else begin
                  mul_out_d = acc_step;
               end
            end
         end

         default: state_d = IDLE;
      endcase

      busy_d = (state_d == RUN);
      done_d = (state_d == DONE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         mode_q     <= 1'b0;
         b_q        <= '0;
         l_q        <= '0;
         mcand_q    <= '0;
         acc_q      <= '0;
         prem_q     <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         mul_out_q  <= '0;
         quot_out_q <= '0;
         rem_out_q  <= '0;
         div_zero_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         mode_q     <= mode_d;
         b_q        <= b_d;
         l_q        <= l_d;
         mcand_q    <= mcand_d;
         acc_q      <= acc_d;
         prem_q     <= prem_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         mul_out_q  <= mul_out_d;
         quot_out_q <= quot_out_d;
         rem_out_q  <= rem_out_d;
         div_zero_q <= div_zero_d;
      end
   end

   assign busy     = busy_q;
   assign done     = done_q;
   assign mul_out  = mul_out_q;
   assign quot_out = quot_out_q;
   assign rem_out  = rem_out_q;
   assign div_zero = div_zero_q;

endmodule

// File: tb/tb_seq_mul_div.sv
// Bench for seq_mul_div: directed N=4 vector table and corner sequences,
// then randomized N=8 operations against an arithmetic reference model.
module tb_seq_mul_div;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   // N = 4 instance
   logic        s4_start = 1'b0, s4_mode = 1'b0;
   logic [3:0]  s4_b = '0;
   logic [7:0]  s4_l = '0;
   logic        s4_busy, s4_done, s4_dz;
   logic [7:0]  s4_mul, s4_quot;
   logic [3:0]  s4_rem;

   seq_mul_div #(.N(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .start(s4_start), .mode(s4_mode),
      .b_in(s4_b), .l_in(s4_l), .busy(s4_busy), .done(s4_done),
      .mul_out(s4_mul), .quot_out(s4_quot), .rem_out(s4_rem), .div_zero(s4_dz)
   );

   // N = 8 instance
   logic        s8_start = 1'b0, s8_mode = 1'b0;
   logic [7:0]  s8_b = '0;
   logic [15:0] s8_l = '0;
   logic        s8_busy, s8_done, s8_dz;
   logic [15:0] s8_mul, s8_quot;
   logic [7:0]  s8_rem;

   seq_mul_div #(.N(8)) dut8 (
      .clk(clk), .rst_n(rst_n), .start(s8_start), .mode(s8_mode),
      .b_in(s8_b), .l_in(s8_l), .busy(s8_busy), .done(s8_done),
      .mul_out(s8_mul), .quot_out(s8_quot), .rem_out(s8_rem), .div_zero(s8_dz)
   );

   int n_cmp = 0;
   int n_fail = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Issue one N=4 op from the current cycle; returns done latency and busy cycle count.
   // A nonzero glitch cycle pulses start with other operands while the op runs.
   task automatic op4(input logic md, input logic [3:0] b, input logic [7:0] l,
                      input int glitch, output int lat, output int bcnt);
      s4_start = 1'b1; s4_mode = md; s4_b = b; s4_l = l;
      lat = 0; bcnt = 0;
      do begin
         @(posedge clk); #1;
         lat++;
         if (lat == glitch) begin
            s4_start = 1'b1; s4_mode = ~md; s4_b = 4'd0; s4_l = 8'h33;
         end else begin
            s4_start = 1'b0; s4_b = 4'h9; s4_l = 8'h66;
         end
         if (s4_busy) bcnt++;
      end while (!s4_done && lat < 40);
      s4_start = 1'b0;
   endtask

   task automatic op8(input logic md, input logic [7:0] b, input logic [15:0] l,
                      output int lat, output int bcnt);
      s8_start = 1'b1; s8_mode = md; s8_b = b; s8_l = l;
      lat = 0; bcnt = 0;
      do begin
         @(posedge clk); #1;
         lat++;
         s8_start = 1'b0; s8_b = 8'($urandom); s8_l = 16'($urandom);
         if (s8_busy) bcnt++;
      end while (!s8_done && lat < 80);
   endtask

   typedef struct {
      logic       md;
      logic [3:0] b;
      logic [7:0] l;
      logic [7:0] e_mul;
      logic [7:0] e_quot;
      logic [3:0] e_rem;
      logic       e_dz;
      int         e_lat;
   } vec_t;

   vec_t vt[11];

   initial begin
      int lat, bcnt;
      logic [15:0] m_mul, m_quot;
      logic [7:0]  m_rem;
      logic        m_dz;

      vt[0]  = '{1'b0, 4'd13, 8'h0B, 8'h8F, 8'h00, 4'h0, 1'b0, 5};
      vt[1]  = '{1'b1, 4'd0,  8'h5A, 8'h8F, 8'hFF, 4'hA, 1'b1, 1};
      vt[2]  = '{1'b1, 4'd5,  8'h00, 8'h8F, 8'h00, 4'h0, 1'b0, 9};
      vt[3]  = '{1'b1, 4'd1,  8'hFF, 8'h8F, 8'hFF, 4'h0, 1'b0, 9};
      vt[4]  = '{1'b0, 4'd15, 8'hAF, 8'hE1, 8'hFF, 4'h0, 1'b0, 5};
      vt[5]  = '{1'b1, 4'd7,  8'hC8, 8'hE1, 8'h1C, 4'h4, 1'b0, 9};
      vt[6]  = '{1'b1, 4'd0,  8'h00, 8'hE1, 8'hFF, 4'h0, 1'b1, 1};
      vt[7]  = '{1'b1, 4'd15, 8'hFF, 8'hE1, 8'h11, 4'h0, 1'b0, 9};
      vt[8]  = '{1'b1, 4'd9,  8'hF0, 8'hE1, 8'h1A, 4'h6, 1'b0, 9};
      vt[9]  = '{1'b0, 4'd7,  8'h30, 8'h00, 8'h1A, 4'h6, 1'b0, 5};
      vt[10] = '{1'b0, 4'd15, 8'h01, 8'h0F, 8'h1A, 4'h6, 1'b0, 5};

      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy", 64'(s4_busy), 64'd0);
      chk("rst_done", 64'(s4_done), 64'd0);
      chk("rst_mul",  64'(s4_mul),  64'd0);
      chk("rst_quot", 64'(s4_quot), 64'd0);
      chk("rst_rem",  64'(s4_rem),  64'd0);
      chk("rst_dz",   64'(s4_dz),   64'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Table runs back-to-back: each op starts in the previous op's done cycle.
      foreach (vt[i]) begin
         op4(vt[i].md, vt[i].b, vt[i].l, 0, lat, bcnt);
         chk($sformatf("vec%0d_lat", i),  64'(lat),     64'(vt[i].e_lat));
         chk($sformatf("vec%0d_busy", i), 64'(bcnt),    64'(vt[i].e_lat - 1));
         chk($sformatf("vec%0d_mul", i),  64'(s4_mul),  64'(vt[i].e_mul));
         chk($sformatf("vec%0d_quot", i), 64'(s4_quot), 64'(vt[i].e_quot));
         chk($sformatf("vec%0d_rem", i),  64'(s4_rem),  64'(vt[i].e_rem));
         chk($sformatf("vec%0d_dz", i),   64'(s4_dz),   64'(vt[i].e_dz));
      end

      // Idle cycle, then start pulsed during RUN must be ignored.
      @(posedge clk); #1;
      chk("idle_done", 64'(s4_done), 64'd0);
      op4(1'b1, 4'd7, 8'd200, 3, lat, bcnt);
      chk("glitch_lat",  64'(lat),     64'd9);
      chk("glitch_quot", 64'(s4_quot), 64'h1C);
      chk("glitch_rem",  64'(s4_rem),  64'h4);
      chk("glitch_mul",  64'(s4_mul),  64'h0F);
      chk("glitch_dz",   64'(s4_dz),   64'd0);
      @(posedge clk); #1;

      // Asynchronous reset in cycle 3 of a divide.
      s4_start = 1'b1; s4_mode = 1'b1; s4_b = 4'd7; s4_l = 8'd200;
      @(posedge clk); #1;
      s4_start = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk("pre_rst_busy", 64'(s4_busy), 64'd1);
      rst_n = 1'b0;
      #1;
      chk("arst_busy", 64'(s4_busy), 64'd0);
      chk("arst_done", 64'(s4_done), 64'd0);
      chk("arst_mul",  64'(s4_mul),  64'd0);
      chk("arst_quot", 64'(s4_quot), 64'd0);
      chk("arst_rem",  64'(s4_rem),  64'd0);
      chk("arst_dz",   64'(s4_dz),   64'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk("post_rst_busy", 64'(s4_busy), 64'd0);
      chk("post_rst_done", 64'(s4_done), 64'd0);
      op4(1'b0, 4'd3, 8'd5, 0, lat, bcnt);
      chk("post_rst_lat",  64'(lat),     64'd5);
      chk("post_rst_mul",  64'(s4_mul),  64'h0F);
      chk("post_rst_quot", 64'(s4_quot), 64'h00);

      // N=8 randomized regression against plain arithmetic.
      m_mul = '0; m_quot = '0; m_rem = '0; m_dz = 1'b0;
      for (int k = 0; k < 300; k++) begin
         logic        md;
         logic [7:0]  b;
         logic [15:0] l;
         int          e_lat;
         md = 1'($urandom);
         b  = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
         l  = 16'($urandom);
         if ($urandom_range(0, 3) == 0) begin
            s8_start = 1'b0;
            repeat ($urandom_range(1, 3)) @(posedge clk);
            #1;
            chk($sformatf("r%0d_idle_busy", k), 64'(s8_busy), 64'd0);
         end
         m_dz = 1'b0;
         if (!md) begin
            m_mul = 16'(b) * 16'(l[7:0]);
            e_lat = 9;
         end else if (b == 8'd0) begin
            m_quot = '1;
            m_rem  = l[7:0];
            m_dz   = 1'b1;
            e_lat  = 1;
         end else begin
            m_quot = l / 16'(b);
            m_rem  = 8'(l % 16'(b));
            e_lat  = 17;
         end
         op8(md, b, l, lat, bcnt);
         chk($sformatf("r%0d_lat", k),  64'(lat),     64'(e_lat));
         chk($sformatf("r%0d_busy", k), 64'(bcnt),    64'(e_lat - 1));
         chk($sformatf("r%0d_mul", k),  64'(s8_mul),  64'(m_mul));
         chk($sformatf("r%0d_quot", k), 64'(s8_quot), 64'(m_quot));
         chk($sformatf("r%0d_rem", k),  64'(s8_rem),  64'(m_rem));
         chk($sformatf("r%0d_dz", k),   64'(s8_dz),   64'(m_dz));
      end
      s8_start = 1'b0;
      @(posedge clk); #1;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
